// File: rtl/bp_be_stride_prefetch_issuer_pkg.sv
// Shared types for the back-end loop inference / stride prefetch path.
// Holds processor config lookups, the loop descriptor bundle and issuer states.
package bp_be_stride_prefetch_issuer_pkg;

   typedef enum logic [0:0] {
      e_bp_default_cfg,
      e_bp_sv39_cfg
   } bp_params_e;

   localparam int bp_default_vaddr_width_gp  = 32;
   localparam int bp_default_dcache_block_gp = 512;
   localparam int bp_default_range_gp        = 8;
   localparam int bp_default_stride_gp       = 8;

   function automatic int bp_vaddr_width(bp_params_e cfg);
      case (cfg)
         e_bp_sv39_cfg: return 39;
         default:       return bp_default_vaddr_width_gp;
      endcase
   endfunction

   function automatic int bp_dcache_block_width(bp_params_e cfg);
      case (cfg)
         e_bp_sv39_cfg: return 512;
         default:       return bp_default_dcache_block_gp;
      endcase
   endfunction

   typedef struct packed {
      logic [bp_default_range_gp-1:0]       iters;
      logic [bp_default_vaddr_width_gp-1:0] pc;
      logic [bp_default_vaddr_width_gp-1:0] eff_addr;
      logic [bp_default_stride_gp-1:0]      stride;
   } bp_be_loop_desc_s;

   typedef enum logic [0:0] {
      e_pf_idle,
      e_pf_issue
   } bp_be_pf_state_e;

endpackage

// File: rtl/bp_be_stride_prefetch_issuer_addr_gen.sv
// Walks eff_addr + k*stride, tracking the last issued cache line and
// the remaining expansion count for the stride prefetch issuer.
module bp_be_stride_prefetch_issuer_addr_gen
   import bp_be_stride_prefetch_issuer_pkg::*;
#(
   parameter int vaddr_width_p  = 32,
   parameter int block_offset_p = 6,
   parameter int output_range_p = 8,
   parameter int stride_width_p = 8,
   parameter int max_prefetch_p = 16
)(
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      load_i,
   input  logic                      advance_i,
   input  logic                      clear_i,
   input  logic [output_range_p-1:0] iters_i,
   input  logic [vaddr_width_p-1:0]  eff_addr_i,
   input  logic [stride_width_p-1:0] stride_i,
   output logic [vaddr_width_p-1:0]  aligned_addr_o,
   output logic                      same_line_o,
   output logic                      last_o
);

   localparam int cnt_width_lp  = $clog2(max_prefetch_p + 1);
   localparam int line_width_lp = vaddr_width_p - block_offset_p;

   logic [vaddr_width_p-1:0]  r_next_addr;
   logic [vaddr_width_p-1:0]  r_stride;
   logic [line_width_lp-1:0]  r_last_line;
   logic [cnt_width_lp-1:0]   r_cnt;

   logic [vaddr_width_p-1:0]  w_stride_ext;
   logic [vaddr_width_p-1:0]  w_first_addr;
   logic [line_width_lp-1:0]  w_cur_line;
   logic [line_width_lp-1:0]  w_eff_line;
   logic                      w_over;
   logic [cnt_width_lp-1:0]   w_load_cnt;

   assign w_stride_ext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}},
                          stride_i};
   assign w_first_addr = eff_addr_i + w_stride_ext;
   assign w_cur_line   = r_next_addr[vaddr_width_p-1:block_offset_p];
   assign w_eff_line   = eff_addr_i[vaddr_width_p-1:block_offset_p];

   // Clamp the descriptor's iteration count to the per-descriptor cap
   assign w_over     = ({1'b0, iters_i} > (output_range_p+1)'(max_prefetch_p));
   assign w_load_cnt = w_over ? cnt_width_lp'(max_prefetch_p)
                              : cnt_width_lp'(iters_i);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_next_addr <= '0;
         r_stride    <= '0;
         r_last_line <= '0;
         r_cnt       <= '0;
      end else if (clear_i) begin
         r_cnt       <= '0;
      end else if (load_i) begin
         r_next_addr <= w_first_addr;
         r_stride    <= w_stride_ext;
         r_last_line <= w_eff_line;
         r_cnt       <= w_load_cnt;
      end else if (advance_i) begin
         r_next_addr <= r_next_addr + r_stride;
         r_last_line <= w_cur_line;
         r_cnt       <= r_cnt - cnt_width_lp'(1);
      end
   end

   assign aligned_addr_o = {w_cur_line, {block_offset_p{1'b0}}};
   assign same_line_o    = (w_cur_line == r_last_line);
   assign last_o         = (r_cnt == cnt_width_lp'(1));

endmodule

// File: rtl/bp_be_stride_prefetch_issuer.sv
// Expands loop descriptors from loop inference into block-aligned D$
// prefetch requests, skipping addresses that fall in the last issued line.
module bp_be_stride_prefetch_issuer
   import bp_be_stride_prefetch_issuer_pkg::*;
#(
   parameter bp_params_e bp_params_p = e_bp_default_cfg,
   parameter int output_range_p       = 8,
   parameter int stride_width_p       = 8,
   parameter int max_prefetch_p       = 16,
   parameter int vaddr_width_p        = bp_vaddr_width(bp_params_p),
   parameter int dcache_block_width_p = bp_dcache_block_width(bp_params_p)
)(
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic [output_range_p-1:0] iters_i,
   input  logic [vaddr_width_p-1:0]  pc_i,
   input  logic [vaddr_width_p-1:0]  eff_addr_i,
   input  logic [stride_width_p-1:0] stride_i,
   input  logic                      v_i,
   output logic                      yumi_o,
   input  logic                      flush_i,
   output logic                      pf_v_o,
   output logic [vaddr_width_p-1:0]  pf_vaddr_o,
   output logic [vaddr_width_p-1:0]  pf_pc_o,
   input  logic                      pf_ready_i,
   output logic                      busy_o
);

   localparam int block_offset_lp = $clog2(dcache_block_width_p / 8);

   bp_be_pf_state_e           r_state;
   logic [vaddr_width_p-1:0]  r_pc;

   logic                      w_idle;
   logic                      w_issue;
   logic                      w_drop;
   logic                      w_same_line;
   logic                      w_last;
   logic                      w_advance;
   logic                      w_clear;
   logic [vaddr_width_p-1:0]  w_aligned;

   assign w_idle  = (r_state == e_pf_idle);
   assign w_issue = (r_state == e_pf_issue);
   assign w_drop  = (iters_i == '0) | (stride_i == '0);

   assign yumi_o  = w_idle & v_i & ~flush_i & ~reset_i;

   // A flush cycle neither presents nor completes a request
   assign pf_v_o    = w_issue & ~flush_i & ~w_same_line;
   assign w_advance = w_issue & ~flush_i & (w_same_line | pf_ready_i);
   assign w_clear   = w_issue & flush_i;

   bp_be_stride_prefetch_issuer_addr_gen #(
      .vaddr_width_p  (vaddr_width_p),
      .block_offset_p (block_offset_lp),
      .output_range_p (output_range_p),
      .stride_width_p (stride_width_p),
      .max_prefetch_p (max_prefetch_p)
   ) u_addr_gen (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .load_i         (yumi_o),
      .advance_i      (w_advance),
      .clear_i        (w_clear),
      .iters_i        (iters_i),
      .eff_addr_i     (eff_addr_i),
      .stride_i       (stride_i),
      .aligned_addr_o (w_aligned),
      .same_line_o    (w_same_line),
      .last_o         (w_last)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= e_pf_idle;
         r_pc    <= '0;
      end else begin
         case (r_state)
            e_pf_idle: begin
               if (yumi_o) begin
                  r_pc <= pc_i;
                  if (!w_drop)
                     r_state <= e_pf_issue;
               end
            end
            e_pf_issue: begin
               if (flush_i)
                  r_state <= e_pf_idle;
               else if (w_advance & w_last)
                  r_state <= e_pf_idle;
            end
            default: r_state <= e_pf_idle;
         endcase
      end
   end

   assign pf_vaddr_o = w_aligned;
   assign pf_pc_o    = r_pc;
   assign busy_o     = w_issue;

endmodule

// File: tb/tb_bp_be_stride_prefetch_issuer.sv
// Directed bench for the stride prefetch issuer: vector table plus
// hand-written stall, flush and reset sequences.
module tb_bp_be_stride_prefetch_issuer;
   import bp_be_stride_prefetch_issuer_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [7:0]  iters_i;
   logic [31:0] pc_i;
   logic [31:0] eff_addr_i;
   logic [7:0]  stride_i;
   logic        v_i;
   logic        yumi_o;
   logic        flush_i;
   logic        pf_v_o;
   logic [31:0] pf_vaddr_o;
   logic [31:0] pf_pc_o;
   logic        pf_ready_i;
   logic        busy_o;

   int n_chk  = 0;
   int n_fail = 0;
   int hs_cnt = 0;

   bp_be_stride_prefetch_issuer dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .iters_i    (iters_i),
      .pc_i       (pc_i),
      .eff_addr_i (eff_addr_i),
      .stride_i   (stride_i),
      .v_i        (v_i),
      .yumi_o     (yumi_o),
      .flush_i    (flush_i),
      .pf_v_o     (pf_v_o),
      .pf_vaddr_o (pf_vaddr_o),
      .pf_pc_o    (pf_pc_o),
      .pf_ready_i (pf_ready_i),
      .busy_o     (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Inputs only change just after posedge, so negedge sees the handshake
   always @(negedge clk_i)
      if (!reset_i && pf_v_o && pf_ready_i)
         hs_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct packed {
      bp_be_loop_desc_s  d;
      int                exp_n;
      int                exp_busy;
      logic [3:0][31:0]  exp_a;
   } vec_t;

   function automatic vec_t mk(logic [7:0] it, logic [31:0] eff,
                               logic [7:0] st, logic [31:0] pc,
                               int n, int busy,
                               logic [31:0] a0, logic [31:0] a1,
                               logic [31:0] a2, logic [31:0] a3);
      vec_t v;
      v.d.iters    = it;
      v.d.pc       = pc;
      v.d.eff_addr = eff;
      v.d.stride   = st;
      v.exp_n      = n;
      v.exp_busy   = busy;
      v.exp_a[0]   = a0;
      v.exp_a[1]   = a1;
      v.exp_a[2]   = a2;
      v.exp_a[3]   = a3;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_desc(logic [7:0] it, logic [31:0] eff,
                             logic [7:0] st, logic [31:0] pc);
      iters_i    = it;
      eff_addr_i = eff;
      stride_i   = st;
      pc_i       = pc;
      v_i        = 1'b1;
   endtask

   vec_t vecs [8];

   initial begin
      int cyc;
      int n;
      int stall;
      int hs0;

      vecs[0] = mk(8'd4, 32'h1000, 8'h40, 32'h8000_0100, 4, 4,
                   32'h1040, 32'h1080, 32'h10C0, 32'h1100);
      vecs[1] = mk(8'd8, 32'h2000, 8'h08, 32'h8000_0200, 1, 8,
                   32'h2040, 32'h0, 32'h0, 32'h0);
      vecs[2] = mk(8'd3, 32'h3000, 8'hC0, 32'h8000_0300, 3, 3,
                   32'h2FC0, 32'h2F80, 32'h2F40, 32'h0);
      vecs[3] = mk(8'd2, 32'hFFFF_FFC0, 8'h40, 32'h8000_0400, 2, 2,
                   32'h0, 32'h40, 32'h0, 32'h0);
      vecs[4] = mk(8'd0, 32'h1000, 8'h40, 32'h8000_0500, 0, 0,
                   32'h0, 32'h0, 32'h0, 32'h0);
      vecs[5] = mk(8'd5, 32'h1000, 8'h00, 32'h8000_0600, 0, 0,
                   32'h0, 32'h0, 32'h0, 32'h0);
      vecs[6] = mk(8'd4, 32'h6010, 8'hF8, 32'h8000_0700, 1, 4,
                   32'h5FC0, 32'h0, 32'h0, 32'h0);
      vecs[7] = mk(8'd2, 32'h7020, 8'h40, 32'h8000_0800, 2, 2,
                   32'h7040, 32'h7080, 32'h0, 32'h0);

      reset_i    = 1'b1;
      iters_i    = '0;
      pc_i       = '0;
      eff_addr_i = '0;
      stride_i   = '0;
      v_i        = 1'b0;
      flush_i    = 1'b0;
      pf_ready_i = 1'b1;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1 v_i = 1'b1;
      #1 chk("yumi_in_reset", yumi_o, 1'b0);
      v_i = 1'b0;
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      #1;
      chk("rst_yumi", yumi_o, 1'b0);
      chk("rst_pf_v", pf_v_o, 1'b0);
      chk("rst_vaddr", pf_vaddr_o, 32'h0);
      chk("rst_pc", pf_pc_o, 32'h0);
      chk("rst_busy", busy_o, 1'b0);

      // Table-driven descriptors with ready held high
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i);
         #1;
         drive_desc(vecs[i].d.iters, vecs[i].d.eff_addr,
                    vecs[i].d.stride, vecs[i].d.pc);
         pf_ready_i = 1'b1;
         #1 chk($sformatf("v%0d_yumi", i), yumi_o, 1'b1);
         @(posedge clk_i);
         #1 v_i = 1'b0;
         #1;
         cyc = 0;
         n   = 0;
         while (busy_o && cyc < 40) begin
            if (pf_v_o) begin
               if (n < 4)
                  chk($sformatf("v%0d_addr%0d", i, n), pf_vaddr_o,
                      vecs[i].exp_a[n]);
               chk($sformatf("v%0d_pc%0d", i, n), pf_pc_o, vecs[i].d.pc);
               n++;
            end
            cyc++;
            @(posedge clk_i);
            #2;
         end
         chk($sformatf("v%0d_npf", i), n, vecs[i].exp_n);
         chk($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].exp_busy);
      end

      // Cap at 16 requests, stall 5 cycles on the third request
      @(posedge clk_i);
      #1 drive_desc(8'd200, 32'h4000, 8'h40, 32'h9000);
      #1 chk("cap_yumi", yumi_o, 1'b1);
      @(posedge clk_i);
      #1 v_i = 1'b0;
      cyc   = 0;
      n     = 0;
      stall = 0;
      hs0   = hs_cnt;
      #1;
      while (busy_o && cyc < 60) begin
         if (pf_v_o) begin
            chk($sformatf("cap_addr%0d", n), pf_vaddr_o,
                32'h4000 + 32'(64 * (n + 1)));
            if (pf_ready_i)
               n++;
            else begin
               stall++;
               chk("cap_yumi_busy", yumi_o, 1'b0);
            end
         end
         cyc++;
         @(posedge clk_i);
         #1;
         pf_ready_i = !(n == 2 && stall < 5);
         v_i        = !pf_ready_i;
         #1;
      end
      pf_ready_i = 1'b1;
      v_i        = 1'b0;
      chk("cap_npf", n, 16);
      chk("cap_hs", hs_cnt - hs0, 16);
      chk("cap_stall", stall, 5);
      chk("cap_cycles", cyc, 21);

      // Flush on the second request
      @(posedge clk_i);
      #1 drive_desc(8'd4, 32'h5000, 8'h40, 32'hA000);
      #1 chk("fl_yumi", yumi_o, 1'b1);
      hs0 = hs_cnt;
      @(posedge clk_i);
      #1 v_i = 1'b0;
      #1;
      chk("fl_pf1_v", pf_v_o, 1'b1);
      chk("fl_pf1_addr", pf_vaddr_o, 32'h5040);
      @(posedge clk_i);
      #1 flush_i = 1'b1;
      #1;
      chk("fl_pf2_v", pf_v_o, 1'b0);
      chk("fl_busy_during", busy_o, 1'b1);
      @(posedge clk_i);
      #1 flush_i = 1'b0;
      #1;
      chk("fl_busy_after", busy_o, 1'b0);
      chk("fl_pf_after", pf_v_o, 1'b0);
      chk("fl_hs", hs_cnt - hs0, 1);

      // Flush while idle holds the descriptor upstream
      @(posedge clk_i);
      #1 drive_desc(8'd4, 32'h5000, 8'h40, 32'hA000);
      flush_i = 1'b1;
      #1 chk("fl_idle_yumi", yumi_o, 1'b0);
      @(posedge clk_i);
      #1 flush_i = 1'b0;
      v_i = 1'b0;
      #1 chk("fl_idle_busy", busy_o, 1'b0);

      // Asynchronous reset mid-expansion
      @(posedge clk_i);
      #1 drive_desc(8'd4, 32'h1000, 8'h40, 32'hB000);
      #1 chk("rs_yumi", yumi_o, 1'b1);
      hs0 = hs_cnt;
      @(posedge clk_i);
      #1 v_i = 1'b0;
      #1 chk("rs_pf_v_before", pf_v_o, 1'b1);
      #1 reset_i = 1'b1;
      #1;
      chk("rs_pf_v", pf_v_o, 1'b0);
      chk("rs_busy", busy_o, 1'b0);
      chk("rs_vaddr", pf_vaddr_o, 32'h0);
      chk("rs_pc", pf_pc_o, 32'h0);
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      #1;
      chk("rs_busy_after", busy_o, 1'b0);
      chk("rs_hs", hs_cnt - hs0, 0);

      @(posedge clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
